cotm32_clint: RTL and testbench

Parametrised core-local interruptor for cotm32. It generalises the single-hart CLINT register map to NUM_HARTS harts, adds a tick prescaler, and adds a debug-halt gate on mtime. The block sits on the data-memory MMR path at BASE_ADDR. It drives msip/mtip to each hart's CSR/trap unit as mip.msip and mip.mtip, and exports mtime for time/rdtime.

---
 rtl/cotm32_priv_pkg.sv | 45 ++++
 rtl/cotm32_clint_if.sv | 23 ++
 rtl/cotm32_clint_timer.sv | 52 +++++
 rtl/cotm32_clint.sv | 146 ++++++++++++++
 tb/tb_cotm32_clint.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cotm32_priv_pkg.sv
// Privileged-architecture constants and helpers for cotm32, including the CLINT register map.
// The CLINT decoder and timer import this package.
package cotm32_priv_pkg;

    localparam logic [15:0] CLINT_OFS_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_OFS_MTIMECMP = 16'h4000;
    localparam logic [15:0] CLINT_OFS_MTIME    = 16'hBFF8;

    localparam int unsigned CLINT_MSIP_STRIDE     = 4;
    localparam int unsigned CLINT_MTIMECMP_STRIDE = 8;
    localparam int unsigned CLINT_MAX_HARTS       = 16;

    // Hart-0 register addresses at the default base.
    typedef enum logic [31:0] {
        ClintMsip0        = 32'h0200_0000,
        ClintMtimecmp0Lo  = 32'h0200_4000,
        ClintMtimecmp0Hi  = 32'h0200_4004,
        ClintMtimeLo      = 32'h0200_BFF8,
        ClintMtimeHi      = 32'h0200_BFFC
    } clint_mmr_addr_t;

    typedef enum logic [1:0] {
        ClintRegNone,
        ClintRegMsip,
        ClintRegMtimecmp,
        ClintRegMtime
    } clint_reg_e;

    // Byte-merge a 32-bit write into one half of a 64-bit register; no carry between halves.
    function automatic logic [63:0] clint_merge_half(input logic [63:0] cur,
                                                     input logic        hi,
                                                     input logic [31:0] wdata,
                                                     input logic [3:0]  wstrb);
        logic [63:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                if (hi) res[32 + 8*b +: 8] = wdata[8*b +: 8];
                else    res[8*b +: 8]      = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cotm32_clint_if.sv
// Memory-mapped register bus between the data-memory path and the CLINT.
interface cotm32_clint_if;

    logic        mmr_req;
    logic        mmr_we;
    logic [31:0] mmr_addr;
    logic [31:0] mmr_wdata;
    logic [3:0]  mmr_wstrb;
    logic        mmr_rvalid;
    logic [31:0] mmr_rdata;
    logic        mmr_err;

    modport master (
        output mmr_req, mmr_we, mmr_addr, mmr_wdata, mmr_wstrb,
        input  mmr_rvalid, mmr_rdata, mmr_err
    );

    modport slave (
        input  mmr_req, mmr_we, mmr_addr, mmr_wdata, mmr_wstrb,
        output mmr_rvalid, mmr_rdata, mmr_err
    );

endinterface

// File: rtl/cotm32_clint_timer.sv
// mtime counter with tick prescaler, debug-halt gate and a byte-write port.
// A software write wins over a coincident tick; the tick is simply lost.
module cotm32_clint_timer
    import cotm32_priv_pkg::*;
#(
    parameter int unsigned MTIME_WIDTH = 64,
    parameter int unsigned TICK_DIV    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mtime_en_i,
    input  logic                   wr_i,
    input  logic                   wr_hi_i,
    input  logic [31:0]            wdata_i,
    input  logic [3:0]             wstrb_i,
    output logic [MTIME_WIDTH-1:0] mtime_o
);

    localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PrescW-1:0]      presc_q, presc_d;
    logic [MTIME_WIDTH-1:0] mtime_q, mtime_d;
    logic                   tick;

    always_comb begin
        tick    = mtime_en_i && (presc_q == PrescW'(TICK_DIV - 1));
        presc_d = presc_q;
        if (mtime_en_i) begin
            presc_d = tick ? '0 : presc_q + PrescW'(1);
        end

        mtime_d = mtime_q;
        if (wr_i) begin
            mtime_d = MTIME_WIDTH'(clint_merge_half(64'(mtime_q), wr_hi_i, wdata_i, wstrb_i));
        end else if (tick) begin
            mtime_d = mtime_q + MTIME_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/cotm32_clint.sv
// Core-local interruptor: per-hart msip/mtimecmp registers, mtime and registered timer compare.
// Every access gets a one-cycle-later response; unmapped accesses flag mmr_err and change nothing.
module cotm32_clint
    import cotm32_priv_pkg::*;
#(
    parameter int unsigned NUM_HARTS   = 1,
    parameter int unsigned MTIME_WIDTH = 64,
    parameter int unsigned TICK_DIV    = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    cotm32_clint_if.slave        mmr,
    input  logic                 mtime_en,
    output logic [NUM_HARTS-1:0] msip_o,
    output logic [NUM_HARTS-1:0] mtip_o,
    output logic [63:0]          mtime_o
);

    localparam int unsigned HartIdxW  = $clog2(CLINT_MAX_HARTS);
    localparam int unsigned MsipShift = $clog2(CLINT_MSIP_STRIDE);
    localparam int unsigned CmpShift  = $clog2(CLINT_MTIMECMP_STRIDE);
    localparam logic [15:0] MsipSpan  = 16'(CLINT_MSIP_STRIDE * NUM_HARTS);
    localparam logic [15:0] CmpSpan   = 16'(CLINT_MTIMECMP_STRIDE * NUM_HARTS);

    logic [NUM_HARTS-1:0]   msip_q, msip_d;
    logic [NUM_HARTS-1:0]   mtip_q, mtip_d;
    logic [MTIME_WIDTH-1:0] mtimecmp_q [NUM_HARTS];
    logic [MTIME_WIDTH-1:0] mtimecmp_d [NUM_HARTS];
    logic                   rvalid_q, rvalid_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [MTIME_WIDTH-1:0] mtime;
    logic [63:0]            mtime_ext;
    logic [15:0]            ofs, msip_rel, cmp_rel;
    logic [HartIdxW-1:0]    hart;
    logic                   sel_hi;
    logic                   wr;
    clint_reg_e             reg_sel;

    assign mtime_ext = 64'(mtime);
    assign wr        = mmr.mmr_req && mmr.mmr_we;

    // Address decode; only word-aligned addresses inside the 64 KiB region can hit.
    always_comb begin
        ofs      = mmr.mmr_addr[15:0];
        msip_rel = ofs - CLINT_OFS_MSIP;
        cmp_rel  = ofs - CLINT_OFS_MTIMECMP;
        sel_hi   = ofs[2];
        hart     = '0;
        reg_sel  = ClintRegNone;
        if (mmr.mmr_addr[31:16] == BASE_ADDR[31:16] && ofs[1:0] == 2'b00) begin
            if (ofs >= CLINT_OFS_MSIP && msip_rel < MsipSpan) begin
                reg_sel = ClintRegMsip;
                hart    = msip_rel[MsipShift +: HartIdxW];
            end else if (ofs >= CLINT_OFS_MTIMECMP && cmp_rel < CmpSpan) begin
                reg_sel = ClintRegMtimecmp;
                hart    = cmp_rel[CmpShift +: HartIdxW];
            end else if (ofs[15:3] == CLINT_OFS_MTIME[15:3]) begin
                reg_sel = ClintRegMtime;
            end
        end
    end

    cotm32_clint_timer #(
        .MTIME_WIDTH (MTIME_WIDTH),
        .TICK_DIV    (TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .mtime_en_i (mtime_en),
        .wr_i       (wr && reg_sel == ClintRegMtime),
        .wr_hi_i    (sel_hi),
        .wdata_i    (mmr.mmr_wdata),
        .wstrb_i    (mmr.mmr_wstrb),
        .mtime_o    (mtime)
    );

    logic [31:0] rd_word;
    logic [63:0] cmp_ext;

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtip_d     = '0;
        rd_word    = '0;
        cmp_ext    = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            cmp_ext   = 64'(mtimecmp_q[h]);
            // Compare uses pre-update values, so a mtimecmp write shows one cycle later.
            mtip_d[h] = (mtime >= mtimecmp_q[h]);
            if (hart == HartIdxW'(h)) begin
                if (reg_sel == ClintRegMsip) begin
                    rd_word = {31'b0, msip_q[h]};
                    if (wr && mmr.mmr_wstrb[0]) msip_d[h] = mmr.mmr_wdata[0];
                end
                if (reg_sel == ClintRegMtimecmp) begin
                    rd_word = sel_hi ? cmp_ext[63:32] : cmp_ext[31:0];
                    if (wr) begin
                        mtimecmp_d[h] = MTIME_WIDTH'(clint_merge_half(cmp_ext, sel_hi,
                                                                      mmr.mmr_wdata,
                                                                      mmr.mmr_wstrb));
                    end
                end
            end
        end
        if (reg_sel == ClintRegMtime) begin
            rd_word = sel_hi ? mtime_ext[63:32] : mtime_ext[31:0];
        end

        rvalid_d = mmr.mmr_req;
        err_d    = mmr.mmr_req && (reg_sel == ClintRegNone);
        rdata_d  = (mmr.mmr_req && !mmr.mmr_we && reg_sel != ClintRegNone) ? rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q   <= '0;
            mtip_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            msip_q   <= msip_d;
            mtip_q   <= mtip_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
            end
        end
    end

    assign mmr.mmr_rvalid = rvalid_q;
    assign mmr.mmr_err    = err_q;
    assign mmr.mmr_rdata  = rdata_q;
    assign msip_o         = msip_q;
    assign mtip_o         = mtip_q;
    assign mtime_o        = mtime_ext;

endmodule

// File: tb/tb_cotm32_clint.sv
// Bench for cotm32_clint (2 harts, TICK_DIV=4): vector table, directed corner sequences,
// then random traffic against a register-map level reference model.
module tb_cotm32_clint;

    localparam int unsigned NH   = 2;
    localparam int unsigned TDIV = 4;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mtime_en = 1'b0;
    logic [NH-1:0] msip, mtip;
    logic [63:0]   mtime;

    cotm32_clint_if bus ();

    cotm32_clint #(
        .NUM_HARTS   (NH),
        .MTIME_WIDTH (64),
        .TICK_DIV    (TDIV),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mmr      (bus),
        .mtime_en (mtime_en),
        .msip_o   (msip),
        .mtip_o   (mtip),
        .mtime_o  (mtime)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        bus.mmr_req   = 1'b1;
        bus.mmr_we    = we;
        bus.mmr_addr  = a;
        bus.mmr_wdata = d;
        bus.mmr_wstrb = s;
        cyc();
        bus.mmr_req   = 1'b0;
        bus.mmr_we    = 1'b0;
    endtask

    // Reference model state.
    logic [63:0] m_mtime;
    int          m_presc;
    bit [NH-1:0] m_msip, m_mtip;
    logic [63:0] m_cmp [NH];
    bit          e_rvalid, e_err;
    logic [31:0] e_rdata;

    function automatic logic [63:0] put_half(input logic [63:0] v, input bit hi,
                                             input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = hi ? v[63:32] : v[31:0];
        for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        return hi ? {w, v[31:0]} : {v[63:32], w};
    endfunction

    // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
    function automatic void mdecode(input logic [31:0] a, output int kind, output int idx,
                                    output bit hi);
        longint unsigned la, o;
        kind = 0; idx = 0; hi = 0;
        la = 64'(a);
        if (la < 64'(BASE) || la >= 64'(BASE) + 'h10000 || la % 4 != 0) return;
        o = la - 64'(BASE);
        if (o < 4 * NH) begin
            kind = 1; idx = int'(o / 4);
        end else if (o >= 'h4000 && o < 'h4000 + 8 * NH) begin
            kind = 2; idx = int'((o - 'h4000) / 8); hi = ((o - 'h4000) % 8) == 4;
        end else if (o == 'hBFF8) begin
            kind = 3;
        end else if (o == 'hBFFC) begin
            kind = 3; hi = 1;
        end
    endfunction

    task automatic model_reset();
        m_mtime = '0; m_presc = 0; m_msip = '0; m_mtip = '0;
        for (int h = 0; h < NH; h++) m_cmp[h] = '1;
        e_rvalid = 0; e_err = 0; e_rdata = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int kind, idx;
        bit hi, tick, req, we;
        logic [63:0] cur;
        bit [NH-1:0] nmtip;
        if (rst) begin
            model_reset();
            return;
        end
        req = bus.mmr_req; we = bus.mmr_we;
        mdecode(bus.mmr_addr, kind, idx, hi);
        e_rvalid = req;
        e_err    = req && kind == 0;
        e_rdata  = '0;
        if (req && !we && kind != 0) begin
            cur = (kind == 1) ? 64'(m_msip[idx]) : (kind == 2) ? m_cmp[idx] : m_mtime;
            e_rdata = hi ? cur[63:32] : cur[31:0];
        end
        for (int h = 0; h < NH; h++) nmtip[h] = (m_mtime >= m_cmp[h]);
        tick = mtime_en && (m_presc == TDIV - 1);
        if (mtime_en) m_presc = (m_presc + 1) % TDIV;
        if (req && we && kind == 3) m_mtime = put_half(m_mtime, hi, bus.mmr_wdata, bus.mmr_wstrb);
        else if (tick) m_mtime = m_mtime + 64'd1;
        if (req && we && kind == 1 && bus.mmr_wstrb[0]) m_msip[idx] = bus.mmr_wdata[0];
        if (req && we && kind == 2) m_cmp[idx] = put_half(m_cmp[idx], hi, bus.mmr_wdata,
                                                          bus.mmr_wstrb);
        m_mtip = nmtip;
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] cand[13] = '{32'h0200_0000, 32'h0200_0004, 32'h0200_0008, 32'h0200_4000,
                              32'h0200_4004, 32'h0200_4008, 32'h0200_400C, 32'h0200_4010,
                              32'h0200_BFF8, 32'h0200_BFFC, 32'h0200_BFF4, 32'h0200_8000,
                              32'h0300_4000};

    initial begin
        bit found;
        logic [31:0] a;
        bus.mmr_req = 0; bus.mmr_we = 0; bus.mmr_addr = '0; bus.mmr_wdata = '0;
        bus.mmr_wstrb = '0;

        cyc(); cyc();
        rst = 0;
        check("reset_mtime", mtime, 64'h0);
        check("reset_msip", 64'(msip), 64'h0);
        check("reset_mtip", 64'(mtip), 64'h0);
        check("reset_rvalid", 64'(bus.mmr_rvalid), 64'h0);
        check("reset_err", 64'(bus.mmr_err), 64'h0);
        check("reset_rdata", 64'(bus.mmr_rdata), 64'h0);

        vecs.push_back('{1'b0, 32'h0200_4000, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h0200_4004, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h0200_400C, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h0200_0000, 32'h0, 4'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0200_0008, 32'h0, 4'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0200_4010, 32'h0, 4'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0200_BFF8, 32'h0, 4'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0200_BFFC, 32'h0, 4'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0300_0000, 32'h0, 4'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h0200_8000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h0200_0008, 32'h1, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h0200_4010, 32'h0, 4'hF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0200_4000, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 32'h0200_0000, 32'h0, 4'h0, 32'h0, 1'b0});
        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            check($sformatf("vec%0d_rvalid", i), 64'(bus.mmr_rvalid), 64'h1);
            check($sformatf("vec%0d_err", i), 64'(bus.mmr_err), 64'(vecs[i].err));
            check($sformatf("vec%0d_rdata", i), 64'(bus.mmr_rdata), 64'(vecs[i].rdata));
            cyc();
            check($sformatf("vec%0d_rvalid_drop", i), 64'(bus.mmr_rvalid), 64'h0);
        end
        check("unmapped_no_change_msip", 64'(msip), 64'h0);
        check("unmapped_no_change_mtime", mtime, 64'h0);

        // Prescaled count and debug halt.
        rst = 1; cyc();
        rst = 0; mtime_en = 1;
        repeat (40) cyc();
        check("count_40_cycles", mtime, 64'd10);
        mtime_en = 0;
        repeat (8) cyc();
        check("halt_holds", mtime, 64'd10);

        // Timer interrupt on hart 1.
        access(1, 32'h0200_4008, 32'd20, 4'hF);
        access(1, 32'h0200_400C, 32'd0, 4'hF);
        check("mtip_before", 64'(mtip), 64'h0);
        mtime_en = 1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc();
            if (mtime == 64'd20) found = 1;
        end
        check("mtime_reach_20", 64'(found), 64'h1);
        mtime_en = 0;
        check("mtip_not_yet", 64'(mtip), 64'h0);
        cyc();
        check("mtip_hart1", 64'(mtip), 64'b10);
        access(1, 32'h0200_4008, 32'hFFFF_FFFF, 4'hF);
        check("mtip_at_cmp_write", 64'(mtip), 64'b10);
        cyc();
        check("mtip_dropped", 64'(mtip), 64'h0);

        // Software interrupt on hart 1.
        access(1, 32'h0200_0004, 32'hFFFF_FFFF, 4'hF);
        check("msip_set", 64'(msip), 64'b10);
        check("msip_wr_rdata", 64'(bus.mmr_rdata), 64'h0);
        access(0, 32'h0200_0004, 32'h0, 4'h0);
        check("msip_readback", 64'(bus.mmr_rdata), 64'h1);
        access(1, 32'h0200_0004, 32'h0, 4'hF);
        check("msip_clear", 64'(msip), 64'h0);

        // mtime write landing on a tick edge: the tick is lost.
        rst = 1; cyc();
        rst = 0; mtime_en = 1;
        repeat (3) cyc();
        access(1, 32'h0200_BFF8, 32'h100, 4'hF);
        check("wr_on_tick", mtime, 64'h100);
        repeat (3) cyc();
        check("wr_then_hold", mtime, 64'h100);
        cyc();
        check("wr_then_tick", mtime, 64'h101);
        mtime_en = 0;
        access(1, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
        check("lo_write_no_carry", mtime, 64'h0000_0000_FFFF_FFFF);
        access(0, 32'h0200_BFFC, 32'h0, 4'h0);
        check("hi_after_lo_write", 64'(bus.mmr_rdata), 64'h0);
        access(1, 32'h0200_BFFC, 32'hAABB_CCDD, 4'b0101);
        check("hi_partial_strobe", mtime, 64'h00BB_00DD_FFFF_FFFF);

        // Reset sampled with a request: response cancelled.
        bus.mmr_req = 1; bus.mmr_we = 0; bus.mmr_addr = 32'h0200_4000; rst = 1;
        cyc();
        bus.mmr_req = 0; rst = 0;
        check("rst_cancel_rvalid", 64'(bus.mmr_rvalid), 64'h0);
        check("rst_cancel_rdata", 64'(bus.mmr_rdata), 64'h0);
        cyc();
        check("rst_cancel_rvalid_next", 64'(bus.mmr_rvalid), 64'h0);

        // Random traffic against the model.
        rst = 1; model_edge(); cyc();
        rst = 0;
        for (int i = 0; i < 1500; i++) begin
            rst = (i == 700);
            mtime_en = ($urandom_range(0, 7) != 0);
            a = cand[$urandom_range(0, 12)];
            bus.mmr_req   = $urandom_range(0, 1);
            bus.mmr_we    = $urandom_range(0, 1);
            bus.mmr_addr  = a;
            bus.mmr_wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if (a[2]) bus.mmr_wdata = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
            else if ($urandom_range(0, 9) == 0) bus.mmr_wdata = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else bus.mmr_wdata = $urandom_range(0, 400);
            model_edge();
            cyc();
            check("rand_rvalid", 64'(bus.mmr_rvalid), 64'(e_rvalid));
            check("rand_err", 64'(bus.mmr_err), 64'(e_err));
            check("rand_rdata", 64'(bus.mmr_rdata), 64'(e_rdata));
            check("rand_msip", 64'(msip), 64'(m_msip));
            check("rand_mtip", 64'(mtip), 64'(m_mtip));
            check("rand_mtime", mtime, m_mtime);
        end
        rst = 0;
        bus.mmr_req = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
